qdr_usr_tester: RTL and testbench

Built-in traffic initiator and checker for the QDR user interface. It writes a deterministic pattern across an address range, reads it back through the read-strobe/data-valid interface, and compares in order. It sits beside the QDR controller on the same divided clock and drives `usr_rd_strb`, `usr_wr_strb`, `usr_addr` and `usr_wr_data`. It also consumes `usr_rd_data`, `usr_rd_dvld` and `phy_rdy`, and reports pass/fail status to a register block.

---
 rtl/qdr_usr_tester_if.sv | 23 ++
 rtl/qdr_usr_tester.sv | 212 +++++++++++++++++++++
 tb/tb_qdr_usr_tester.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdr_usr_tester_if.sv
// QDR user-side request/response bundle between the traffic tester (master) and the
// QDR controller (slave).
interface qdr_usr_tester_if #(
    parameter int unsigned DATA_WIDTH = 36
) ();
    logic                    phy_rdy;
    logic                    usr_rd_strb;
    logic                    usr_wr_strb;
    logic [31:0]             usr_addr;
    logic [2*DATA_WIDTH-1:0] usr_wr_data;
    logic [2*DATA_WIDTH-1:0] usr_rd_data;
    logic                    usr_rd_dvld;

    modport master (
        output usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data,
        input  usr_rd_data, usr_rd_dvld, phy_rdy
    );

    modport slave (
        input  usr_rd_strb, usr_wr_strb, usr_addr, usr_wr_data,
        output usr_rd_data, usr_rd_dvld, phy_rdy
    );
endinterface

// File: rtl/qdr_usr_tester.sv
// QDR user-interface traffic initiator/checker: writes (seed ^ addr) over 0..test_len, reads it
// back in order and counts mismatches. Macro QDR_TESTER_INVPASS_EN adds an inverted second pass.
module qdr_usr_tester #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  start,
    input  logic [31:0]           seed,
    input  logic [ADDR_WIDTH-1:0] test_len,
    qdr_usr_tester_if.master      usr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout,
    output logic                  aborted
);
    localparam int unsigned       WordW    = 2 * DATA_WIDTH;
    localparam int unsigned       Reps     = (WordW + 31) / 32;
    localparam int unsigned       TimerW   = $clog2(TIMEOUT + 1);
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);
`ifdef QDR_TESTER_INVPASS_EN
    localparam logic InvPassEn = 1'b1;
`else
    localparam logic InvPassEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StWrite, StGap, StRead, StDrain, StDone} state_e;

    function automatic logic [WordW-1:0] f_pat(input logic [31:0] s,
                                               input logic [ADDR_WIDTH-1:0] a, input logic inv);
        logic [WordW-1:0] p;
        p = WordW'({Reps{s ^ 32'(a)}});
        return inv ? ~p : p;
    endfunction

    state_e                r_state;
    logic [31:0]           r_seed;
    logic [ADDR_WIDTH-1:0] r_len, r_addr, r_exp, r_first;
    logic [2:0]            r_gap;
    logic                  r_inv, r_wr_strb, r_rd_strb;
    logic [WordW-1:0]      r_wr_data;
    logic [ADDR_WIDTH:0]   r_out;
    logic [TimerW-1:0]     r_timer;
    logic [15:0]           r_err;
    logic                  r_busy, r_done, r_pass, r_timeout, r_aborted;

    logic                  w_accept, w_dv_exp, w_err_hit, w_active;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH:0]   w_out_d;
    logic [TimerW-1:0]     w_timer_d;
    logic [15:0]           w_err_d;

    assign w_accept   = (r_state == StIdle || r_state == StDone) && start && usr.phy_rdy;
    assign w_active   = r_state inside {StWrite, StGap, StRead, StDrain};
    // A response with nothing outstanding is an error and is never compared.
    assign w_dv_exp   = usr.usr_rd_dvld && (r_out != '0);
    assign w_err_hit  = (usr.usr_rd_dvld && (r_out == '0)) ||
                        (w_dv_exp && (usr.usr_rd_data != f_pat(r_seed, r_exp, r_inv)));
    assign w_addr_inc = r_addr + 1'b1;
    assign w_err_d    = (w_err_hit && r_err != 16'hFFFF) ? r_err + 1'b1 : r_err;

    always_comb begin
        w_out_d = r_out;
        if (r_rd_strb && !w_dv_exp) begin
            w_out_d = r_out + 1'b1;
        end else if (!r_rd_strb && w_dv_exp) begin
            w_out_d = r_out - 1'b1;
        end
    end

    // Timer holds cycles elapsed since the last response, saturating at TIMEOUT.
    always_comb begin
        w_timer_d = r_timer;
        if (usr.usr_rd_dvld) begin
            w_timer_d = TimerW'(1);
        end else if (r_timer != TimerMax) begin
            w_timer_d = r_timer + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= StIdle;
            r_seed    <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_exp     <= '0;
            r_first   <= '0;
            r_gap     <= '0;
            r_inv     <= 1'b0;
            r_wr_strb <= 1'b0;
            r_rd_strb <= 1'b0;
            r_wr_data <= '0;
            r_out     <= '0;
            r_timer   <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_out     <= w_out_d;
            r_timer   <= w_timer_d;
            r_err     <= w_err_d;
            r_wr_strb <= 1'b0;
            r_rd_strb <= 1'b0;
            if (w_err_hit && r_err == '0) r_first <= r_exp;
            if (w_dv_exp) r_exp <= r_exp + 1'b1;
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        r_state   <= StWrite;
                        r_seed    <= seed;
                        r_len     <= test_len;
                        r_inv     <= 1'b0;
                        r_addr    <= '0;
                        r_wr_strb <= 1'b1;
                        r_wr_data <= f_pat(seed, '0, 1'b0);
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_err     <= '0;
                        r_first   <= '0;
                        r_timeout <= 1'b0;
                        r_aborted <= 1'b0;
                        r_out     <= '0;
                        r_timer   <= '0;
                    end
                end
                StWrite: begin
                    if (r_addr == r_len) begin
                        r_state <= StGap;
                        r_gap   <= '0;
                    end else begin
                        r_addr    <= w_addr_inc;
                        r_wr_strb <= 1'b1;
                        r_wr_data <= f_pat(r_seed, w_addr_inc, r_inv);
                    end
                end
                StGap: begin
                    if (r_gap == 3'd7) begin
                        r_state   <= StRead;
                        r_addr    <= '0;
                        r_rd_strb <= 1'b1;
                        r_exp     <= '0;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                StRead: begin
                    if (r_addr == r_len) begin
                        r_state <= StDrain;
                    end else begin
                        r_addr    <= w_addr_inc;
                        r_rd_strb <= 1'b1;
                    end
                end
                StDrain: begin
                    if (r_out == '0) begin
                        if (InvPassEn && !r_inv) begin
                            r_state   <= StWrite;
                            r_inv     <= 1'b1;
                            r_addr    <= '0;
                            r_wr_strb <= 1'b1;
                            r_wr_data <= f_pat(r_seed, '0, 1'b1);
                        end else begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_d == '0);
                        end
                    end else if (w_timer_d == TimerMax) begin
                        r_state   <= StDone;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Losing the PHY overrides every in-flight decision above.
            if (w_active && !usr.phy_rdy) begin
                r_state   <= StDone;
                r_wr_strb <= 1'b0;
                r_rd_strb <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
                r_aborted <= 1'b1;
            end
        end
    end

    assign usr.usr_wr_strb = r_wr_strb;
    assign usr.usr_rd_strb = r_rd_strb;
    assign usr.usr_addr    = 32'(r_addr);
    assign usr.usr_wr_data = r_wr_data;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_addr  = r_first;
    assign timeout         = r_timeout;
    assign aborted         = r_aborted;
endmodule

// File: tb/tb_qdr_usr_tester.sv
// Self-checking bench for qdr_usr_tester: loopback memory with 10-cycle read latency plus a
// cycle-based behavioural model derived from the pass schedule and compare rules.
module tb_qdr_usr_tester;
    localparam int unsigned DW = 36;
    localparam int unsigned AW = 6;
    localparam int unsigned TO = 64;
    localparam int unsigned W  = 2 * DW;
`ifdef QDR_TESTER_INVPASS_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    localparam int NP = INV ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   seed = '0;
    logic [AW-1:0] test_len = '0;
    logic          busy, done, pass_o, timeout_o, aborted_o;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    always #5 clk = ~clk;

    qdr_usr_tester_if #(.DATA_WIDTH(DW)) bus ();

    qdr_usr_tester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .start          (start),
        .seed           (seed),
        .test_len       (test_len),
        .usr            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass_o),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .timeout        (timeout_o),
        .aborted        (aborted_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int c = 0;

    // Model state: values the DUT must show in the current cycle.
    bit            m_active = 0, m_inv = 0, m_busy = 0, m_done = 0, m_pass = 0;
    bit            m_timeout = 0, m_aborted = 0;
    int            m_err = 0, m_out = 0, m_ps = 0, m_last = 0;
    logic [AW-1:0] m_exp = '0, m_first = '0, m_len = '0;
    logic [31:0]   m_seed = '0;

    typedef struct {int due; logic [W-1:0] d;} resp_t;
    resp_t          rq[$];
    logic [W-1:0]   mem [int];

    bit k_start = 0, k_stray = 0, k_drop = 0, k_abort7 = 0, k_phy = 1;
    int k_flip = -1;
    int n_wr, n_rd, last_dv_c, t_rise;
    bit got_first;
    logic [W-1:0] first_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, c, act, req);
        end
    endtask

    function automatic logic [W-1:0] pat(input logic [AW-1:0] a, input bit inv);
        logic [31:0]  v;
        logic [W-1:0] p;
        v = m_seed ^ 32'(a);
        for (int i = 0; i < int'(W); i++) p[i] = v[i % 32];
        return inv ? ~p : p;
    endfunction

    // Pass schedule: N writes from cycle ps+1, 8 idle cycles, then N reads.
    function automatic void exp_strobes(input int cc, output bit wr, output bit rd, output int a);
        int n, k;
        wr = 0; rd = 0; a = 0;
        n = int'(m_len) + 1;
        k = cc - m_ps;
        if (m_active) begin
            if (k >= 1 && k <= n) begin
                wr = 1; a = k - 1;
            end else if (k >= n + 9 && k <= 2 * n + 8) begin
                rd = 1; a = k - n - 9;
            end
        end
    endfunction

    task automatic finish_run(input bit p);
        m_active = 0; m_busy = 0; m_done = 1; m_pass = p;
    endtask

    task automatic model_step(input int cc, input bit st, input bit phy, input bit dv,
                              input logic [W-1:0] rd);
        bit ew, er, hit;
        int ea, old_out, k, n;
        exp_strobes(cc, ew, er, ea);
        n = int'(m_len) + 1;
        k = cc - m_ps;
        old_out = m_out;
        hit = 0;
        if (dv) hit = (old_out == 0) || (rd !== pat(m_exp, m_inv));
        if (hit && m_err == 0) m_first = m_exp;
        if (dv && old_out != 0) m_exp = m_exp + 1'b1;
        if (hit && m_err < 65535) m_err++;
        m_out = old_out + (er ? 1 : 0) - ((dv && old_out != 0) ? 1 : 0);
        if (dv) m_last = cc;
        if (!m_active) begin
            if (st && phy) begin
                m_active = 1; m_busy = 1; m_done = 0; m_pass = 0; m_timeout = 0; m_aborted = 0;
                m_err = 0; m_first = '0; m_out = 0; m_last = cc + 1; m_ps = cc; m_inv = 0;
                m_seed = seed; m_len = test_len;
            end
        end else if (!phy) begin
            m_aborted = 1;
            finish_run(0);
        end else if (k >= 2 * n + 9) begin
            if (old_out == 0) begin
                if (INV && !m_inv) begin
                    m_inv = 1; m_ps = cc;
                end else begin
                    finish_run(m_err == 0);
                end
            end else if (!dv && cc - m_last + 1 >= int'(TO)) begin
                m_timeout = 1;
                finish_run(0);
            end
        end
        if (m_active && cc + 1 - m_ps == int'(m_len) + 10) m_exp = '0;
    endtask

    task automatic tick();
        bit ew, er, dv, phy;
        int ea, a;
        logic [W-1:0] rd, d;
        @(negedge clk);
        c++;
        exp_strobes(c, ew, er, ea);
        chk("wr_strb", bus.usr_wr_strb, ew);
        chk("rd_strb", bus.usr_rd_strb, er);
        if (ew || er) chk("usr_addr", bus.usr_addr, ea);
        if (ew) chk("wr_data", bus.usr_wr_data, pat(ea[AW-1:0], m_inv));
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pass", pass_o, m_pass);
        chk("err_count", err_count, m_err);
        chk("first_err_addr", first_err_addr, m_first);
        chk("timeout", timeout_o, m_timeout);
        chk("aborted", aborted_o, m_aborted);
        if (timeout_o && t_rise < 0) t_rise = c;
        // Loopback controller
        a = int'(bus.usr_addr);
        if (bus.usr_wr_strb) begin
            mem[a] = bus.usr_wr_data;
            n_wr++;
            if (!got_first) begin first_wdata = bus.usr_wr_data; got_first = 1; end
        end
        if (bus.usr_rd_strb) begin
            n_rd++;
            d = mem.exists(a) ? mem[a] : '0;
            if (a == k_flip) d[3] = ~d[3];
            if (!(k_drop && a == int'(test_len))) rq.push_back('{due: c + 10, d: d});
        end
        dv = 0;
        rd = '0;
        if (rq.size() > 0 && rq[0].due == c) begin
            dv = 1; rd = rq[0].d; void'(rq.pop_front());
        end
        if (k_stray) begin
            dv = 1; rd = {$urandom, $urandom, $urandom};
        end
        phy = k_phy;
        if (k_abort7 && bus.usr_rd_strb && a == 7) begin
            phy = 0; k_abort7 = 0;
        end
        bus.phy_rdy     = phy;
        bus.usr_rd_dvld = dv;
        bus.usr_rd_data = rd;
        start           = k_start;
        if (dv) last_dv_c = c;
        model_step(c, k_start, phy, dv, rd);
        k_start = 0;
        k_stray = 0;
    endtask

    task automatic run(input logic [31:0] s, input logic [AW-1:0] len);
        n_wr = 0; n_rd = 0; t_rise = -1; got_first = 0;
        seed = s; test_len = len; k_start = 1;
        tick();
        for (int i = 0; i < 3000 && m_active; i++) tick();
        if (m_active) begin
            n_cmp++; n_bad++;
            $display("FAIL run_bound cycle %0d: got still busy want done", c);
        end
        repeat (12) tick();
    endtask

    initial begin
        bus.phy_rdy     = 1'b1;
        bus.usr_rd_dvld = 1'b0;
        bus.usr_rd_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_count, 16'd0);
        chk("rst_strobes", {bus.usr_wr_strb, bus.usr_rd_strb}, 2'b00);

        k_stray = 1;
        tick();
        tick();
        chk("stray_err", err_count, 16'd1);

        run(32'hA5A5A5A5, 6'd15);
        chk("a_done", done, 1'b1);
        chk("a_pass", pass_o, 1'b1);
        chk("a_err", err_count, 16'd0);
        chk("a_pat0", first_wdata, 72'hA5_A5A5A5A5_A5A5A5A5);
        chk("a_nwr", n_wr, 16 * NP);
        chk("a_nrd", n_rd, 16 * NP);

        k_flip = 5;
        run(32'hA5A5A5A5, 6'd15);
        k_flip = -1;
        chk("b_err", err_count, NP);
        chk("b_first", first_err_addr, 6'd5);
        chk("b_pass", pass_o, 1'b0);

        k_drop = 1;
        run(32'hA5A5A5A5, 6'd15);
        k_drop = 0;
        chk("c_timeout", timeout_o, 1'b1);
        chk("c_delay", t_rise - last_dv_c, TO);
        chk("c_pass", pass_o, 1'b0);

        k_abort7 = 1;
        run(32'h1234_5678, 6'd15);
        chk("d_aborted", aborted_o, 1'b1);
        chk("d_done", done, 1'b1);
        chk("d_pass", pass_o, 1'b0);
        chk("d_nrd", n_rd, 8);
        k_phy = 0; k_start = 1;
        tick();
        repeat (3) tick();
        chk("d_ignored_busy", busy, 1'b0);
        chk("d_ignored_done", done, 1'b1);
        k_phy = 1;
        tick();

        run(32'hDEADBEEF, 6'd0);
        chk("e_nwr", n_wr, NP);
        chk("e_nrd", n_rd, NP);
        chk("e_pass", pass_o, 1'b1);

        run(32'h0F0F_3C3C, 6'd3);
        chk("f_nwr", n_wr, 4 * NP);
        chk("f_nrd", n_rd, 4 * NP);
        chk("f_pass", pass_o, 1'b1);

        run($urandom, 6'd63);
        chk("full_pass", pass_o, 1'b1);

        for (int r = 0; r < 12; r++) begin
            int f;
            logic [AW-1:0] len;
            len = AW'($urandom_range(0, 20));
            f = $urandom_range(0, 2);
            if (f == 1) k_flip = $urandom_range(0, int'(len));
            if (f == 2) k_drop = 1;
            run($urandom, len);
            k_flip = -1;
            k_drop = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
